alu_mul_seq: RTL and testbench

Multi-cycle 64×64→64 (low half) multiply sequencer in front of the shared `dev_alu`. It has no multiplier of its own: it runs the ALU's 16×16 `ALU_MULW`, `ALU_SHR`, `ALU_SHL` and `ALU_ADD` operations over all needed 16-bit chunk pairs and accumulates the result. It also arbitrates ALU ownership: while idle it forwards the CPU's ALU request unchanged, and while busy it owns the ALU and stalls the CPU.

---
 rtl/alu_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle WIDTH x WIDTH -> WIDTH (low half) multiply sequencer that sits
// in front of the shared ALU. It has no multiplier of its own. Instead it
// walks every 16-bit chunk pair (i, j) with i + j < C and issues five ALU
// operations per pair, accumulating the partial products:
//   step 0: SHR  x >> 16*i          -> t
//   step 1: SHR  y >> 16*j          -> u
//   step 2: MULW t[15:0] * u[15:0]  -> p
//   step 3: SHL  p << 16*(i+j)      -> p
//   step 4: ADD  p + acc            -> acc
// While idle, the CPU's ALU request passes straight through. While running,
// the sequencer owns the ALU and stalls the CPU.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   start, x, y         multiply request and operands (sampled in IDLE only)
//   busy, done          sequencer owns ALU / one-cycle completion pulse
//   product             low WIDTH bits of x*y, held until the next start
//   cpu_op/a/b          CPU ALU request
//   cpu_stall           CPU must wait (equals busy)
//   alu_op/a/b          request driven to the ALU
//   alu_s               ALU result, combinational in the same cycle
// ---------------------------------------------------------------------------

package pkg_reg;
    localparam int REG_WIDTH = 64;
endpackage

package pkg_alu;
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_MULW = 4'd8
    } alu_op_t;
endpackage

module alu_mul_seq
    import pkg_alu::*;
#(
    parameter int WIDTH = pkg_reg::REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    input  alu_op_t          cpu_op,
    input  logic [WIDTH-1:0] cpu_a,
    input  logic [WIDTH-1:0] cpu_b,
    output logic             cpu_stall,
    output alu_op_t          alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s
);

    localparam int C  = WIDTH / 16;
    localparam int IW = $clog2(C) + 1;
    localparam logic [IW-1:0] LAST_I = IW'(C - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    i;
    logic [IW-1:0]    j;
    logic [2:0]       step;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] acc;

    logic [IW:0]      ij_sum;
    logic [WIDTH-1:0] sh_i;
    logic [WIDTH-1:0] sh_j;
    logic [WIDTH-1:0] sh_ij;
    logic             last_j;
    logic             last_pair;

    // Shift amounts are chunk index * 16, zero-extended to the operand width.
    assign ij_sum = {1'b0, i} + {1'b0, j};
    assign sh_i   = WIDTH'({i, 4'b0000});
    assign sh_j   = WIDTH'({j, 4'b0000});
    assign sh_ij  = WIDTH'({ij_sum, 4'b0000});

    // Inner loop stops at j = C-1-i: higher pairs only touch the upper half.
    assign last_j    = (j == LAST_I - i);
    // The last row (i = C-1) holds exactly one pair, so reaching it means done.
    assign last_pair = (i == LAST_I);

    assign busy      = (state == S_RUN);
    assign cpu_stall = busy;

    // ALU ownership mux: pure function of state, so no bubble at either end.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        alu_op = cpu_op;
        alu_a  = cpu_a;
        alu_b  = cpu_b;
        if (state == S_RUN) begin
            case (step)
                3'd0: begin alu_op = ALU_SHR;  alu_a = sh_i;  alu_b = x_q; end
                3'd1: begin alu_op = ALU_SHR;  alu_a = sh_j;  alu_b = y_q; end
                3'd2: begin alu_op = ALU_MULW; alu_a = t;     alu_b = u;   end
                3'd3: begin alu_op = ALU_SHL;  alu_a = sh_ij; alu_b = p;   end
                3'd4: begin alu_op = ALU_ADD;  alu_a = p;     alu_b = acc; end
                default: begin alu_op = ALU_NOP; alu_a = '0; alu_b = '0; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= S_IDLE;
            i       <= '0;
            j       <= '0;
            step    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            t       <= '0;
            u       <= '0;
            p       <= '0;
            acc     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        y_q   <= y;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        step  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    case (step)
                        3'd0: begin t <= alu_s; step <= 3'd1; end
                        3'd1: begin u <= alu_s; step <= 3'd2; end
                        3'd2: begin p <= alu_s; step <= 3'd3; end
                        3'd3: begin p <= alu_s; step <= 3'd4; end
                        3'd4: begin
                            acc  <= alu_s;
                            step <= 3'd0;
                            if (last_pair) begin
                                product <= alu_s;
                                done    <= 1'b1;
                                state   <= S_IDLE;
                            end else if (last_j) begin
                                i <= i + IW'(1);
                                j <= '0;
                            end else begin
                                j <= j + IW'(1);
                            end
                        end
                        default: step <= 3'd0;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Directed bench for alu_mul_seq. A small behavioural ALU (with a hold
// register returned on NOP) closes the loop on alu_op/a/b -> alu_s.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;
    import pkg_alu::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] product;
    alu_op_t      cpu_op = ALU_NOP;
    logic [W-1:0] cpu_a = '0;
    logic [W-1:0] cpu_b = '0;
    logic         cpu_stall;
    alu_op_t      alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_s;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_product = '0;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .product(product),
        .cpu_op(cpu_op), .cpu_a(cpu_a), .cpu_b(cpu_b), .cpu_stall(cpu_stall),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: shifts take the amount on a and the value on b.
    logic [W-1:0] hold;
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_s = alu_a + alu_b;
            ALU_SUB:  alu_s = alu_a - alu_b;
            ALU_SHL:  alu_s = alu_b << alu_a;
            ALU_SHR:  alu_s = alu_b >> alu_a;
            ALU_MULW: alu_s = 64'(alu_a[15:0]) * 64'(alu_b[15:0]);
            default:  alu_s = hold;
        endcase
    end
    always @(posedge clk) if (alu_op != ALU_NOP) hold <= alu_s;

    // One multiply: pulse start, count busy cycles, check done/product.
    // ign_at >= 1 re-pulses start (with other operands) at that RUN cycle.
    task automatic do_mul(input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input logic [W-1:0] ev, input int ign_at);
        int cyc;
        bit held_ok;
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = ~xv; y = ~yv;
        cyc = 0;
        held_ok = 1'b1;
        while (busy === 1'b1 && cyc < 200) begin
            if (product !== last_product || done !== 1'b0) held_ok = 1'b0;
            cyc++;
            start = (cyc == ign_at);
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (cyc != 50) begin
            miscompares++; $display("FAIL mul_busy_cycles: got %0d expected 50", cyc);
        end
        vectors++;
        if (!held_ok) begin
            miscompares++; $display("FAIL mul_product_hold: product/done changed during RUN (expected %h)", last_product);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++; $display("FAIL mul_done: got %b expected 1", done);
        end
        vectors++;
        if (product !== ev) begin
            miscompares++; $display("FAIL mul_product: got %h expected %h", product, ev);
        end
        last_product = ev;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || product !== ev) begin
            miscompares++; $display("FAIL mul_after_done: done %b product %h expected 0 / %h", done, product, ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cpu_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: busy %b stall %b expected 0", busy, cpu_stall);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if (product !== 64'd0) begin
            miscompares++; $display("FAIL reset_product: got %h expected 0", product);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cpu_op = ALU_ADD; cpu_a = 64'd7; cpu_b = 64'd9;
        #1;
        vectors++;
        if (alu_op !== ALU_ADD || alu_a !== 64'd7 || alu_b !== 64'd9 || alu_s !== 64'd16) begin
            miscompares++; $display("FAIL reset_passthrough: op %0d a %h b %h s %h expected 1/7/9/16", alu_op, alu_a, alu_b, alu_s);
        end
    endtask

    task automatic test_basic();
        cpu_op = ALU_NOP;
        do_mul(64'd3, 64'd5, 64'd15, -1);
        #1;
        vectors++;
        if (alu_s !== 64'd15) begin
            miscompares++; $display("FAIL basic_nop_readback: got %h expected %h", alu_s, 64'd15);
        end
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        cpu_op = ALU_ADD; cpu_a = 64'd1; cpu_b = 64'd2;
        #1;
        vectors++;
        if (alu_s !== 64'd3 || cpu_stall !== 1'b0) begin
            miscompares++; $display("FAIL arb_idle_add: s %h stall %b expected 3/0", alu_s, cpu_stall);
        end
        cpu_op = ALU_NOP;
    endtask

    task automatic test_wrap();
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, -1);
        do_mul(64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000, 64'd0, -1);
    endtask

    task automatic test_zero();
        do_mul(64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, -1);
    endtask

    // Every ALU request of the 50-step sequence, with the CPU inputs toggled
    // each cycle to show they do not leak through while busy.
    task automatic test_mixed();
        logic [W-1:0] xv, yv, mt, mu, mp, macc, ea, eb;
        alu_op_t eop;
        int cyc;
        xv = 64'h0001_0002_0003_0004;
        yv = 64'h0005_0006_0007_0008;
        macc = '0; mt = '0; mu = '0; mp = '0;
        cyc = 0;
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4 - i; j++) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    start = 1'b0; x = '0; y = '0;
                    cpu_op = (cyc % 2 == 0) ? ALU_SUB : ALU_ADD;
                    cpu_a = 64'(cyc * 977); cpu_b = ~64'(cyc);
                    #1;
                    case (s)
                        0: begin eop = ALU_SHR;  ea = 64'(16 * i);       eb = xv;   mt = xv >> (16 * i); end
                        1: begin eop = ALU_SHR;  ea = 64'(16 * j);       eb = yv;   mu = yv >> (16 * j); end
                        2: begin eop = ALU_MULW; ea = mt;                eb = mu;   mp = 64'(mt[15:0]) * 64'(mu[15:0]); end
                        3: begin eop = ALU_SHL;  ea = 64'(16 * (i + j)); eb = mp;   mp = mp << (16 * (i + j)); end
                        default: begin eop = ALU_ADD; ea = mp;           eb = macc; macc = macc + mp; end
                    endcase
                    vectors++;
                    if (alu_op !== eop || alu_a !== ea || alu_b !== eb) begin
                        miscompares++;
                        $display("FAIL mixed_seq[%0d]: op %0d a %h b %h expected %0d %h %h", cyc, alu_op, alu_a, alu_b, eop, ea, eb);
                    end
                    vectors++;
                    if (cpu_stall !== 1'b1 || busy !== 1'b1) begin
                        miscompares++; $display("FAIL mixed_stall[%0d]: stall %b busy %b expected 1", cyc, cpu_stall, busy);
                    end
                    cyc++;
                end
            end
        end
        cpu_op = ALU_NOP;
        @(negedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || product !== 64'h003C_003D_0034_0020) begin
            miscompares++; $display("FAIL mixed_product: done %b product %h expected 1 / 003c003d00340020", done, product);
        end
        vectors++;
        if (alu_s !== 64'h003C_003D_0034_0020 || macc !== 64'h003C_003D_0034_0020) begin
            miscompares++; $display("FAIL mixed_nop_readback: alu_s %h model %h expected 003c003d00340020", alu_s, macc);
        end
        last_product = 64'h003C_003D_0034_0020;
    endtask

    task automatic test_start_ignored();
        bit quiet;
        do_mul(64'd11, 64'd13, 64'd143, 20);
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++; $display("FAIL start_ignored: extra busy/done seen, expected none");
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        x = 64'd3; y = 64'd5; start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        vectors++;
        if (cyc != 50 || done !== 1'b1 || product !== 64'd15) begin
            miscompares++; $display("FAIL b2b_first: cycles %0d done %b product %h expected 50/1/f", cyc, done, product);
        end
        x = 64'd7; y = 64'd9;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL b2b_restart: busy %b done %b expected 1/0", busy, done);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
        vectors++;
        if (cyc != 50 || done !== 1'b1 || product !== 64'd63) begin
            miscompares++; $display("FAIL b2b_second: cycles %0d done %b product %h expected 50/1/3f", cyc, done, product);
        end
        last_product = 64'd63;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        x = 64'h1234; y = 64'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_op = ALU_ADD; cpu_a = 64'd40; cpu_b = 64'd2;
        #1;
        vectors++;
        if (busy !== 1'b0 || cpu_stall !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_state: busy %b stall %b done %b expected 0", busy, cpu_stall, done);
        end
        vectors++;
        if (product !== 64'd0) begin
            miscompares++; $display("FAIL rstmid_product: got %h expected 0", product);
        end
        vectors++;
        if (alu_op !== ALU_ADD || alu_s !== 64'd42) begin
            miscompares++; $display("FAIL rstmid_passthrough: op %0d s %h expected 1/2a", alu_op, alu_s);
        end
        cpu_op = ALU_NOP;
        last_product = 64'd0;
        do_mul(64'd6, 64'd7, 64'd42, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_wrap();
        test_zero();
        test_mixed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
